// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues req/ack reads to a
// variable-latency instruction memory and buffers returned instructions in a
// small FIFO ahead of the IF/ID register. Branch redirects flush the FIFO and
// restart fetch at the target; a request still in flight at redirect time is
// completed and its data thrown away (DROP state).
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         stall_i,
  input  logic                         redirect_i,
  input  logic [31:0]                  redirect_pc_i,
  output logic                         imem_req_o,
  output logic [31:0]                  imem_addr_o,
  input  logic                         imem_ack_i,
  input  logic [31:0]                  imem_data_i,
  output logic                         valid_o,
  output logic [31:0]                  inst_o,
  output logic [31:0]                  addr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t          state_r;
  logic [31:0]     fpc_r;
  logic            req_r;
  logic [31:0]     req_addr_r;
  logic [CW-1:0]   count_r;
  logic            valid_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [31:0]     inst_mem_r [DEPTH];
  logic [31:0]     addr_mem_r [DEPTH];

  logic            push_s;
  logic            pop_s;
  logic [CW-1:0]   count_nxt_s;
  logic [31:0]     fpc_nxt_s;
  logic            room_s;

  // Push/pop qualification, next occupancy and next fetch PC (redirect wins)
  always_comb begin
    push_s      = 1'b0;
    pop_s       = 1'b0;
    count_nxt_s = count_r;
    fpc_nxt_s   = fpc_r;
    if (redirect_i) begin
      count_nxt_s = {CW{1'b0}};
      fpc_nxt_s   = redirect_pc_i;
    end else begin
      push_s = (state_r == FETCH) && imem_ack_i;
      pop_s  = valid_r && !stall_i;
      if (push_s && !pop_s) begin
        count_nxt_s = count_r + CW'(1);
      end else if (pop_s && !push_s) begin
        count_nxt_s = count_r - CW'(1);
      end else begin
        count_nxt_s = count_r;
      end
      if (push_s) begin
        fpc_nxt_s = fpc_r + 32'd4;
      end else begin
        fpc_nxt_s = fpc_r;
      end
    end
    room_s = (count_nxt_s < CW'(DEPTH));
  end

  // Fetch FSM with registered request/address; address is frozen until ack
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= IDLE;
      fpc_r      <= RESET_PC;
      req_r      <= 1'b0;
      req_addr_r <= RESET_PC;
    end else begin
      fpc_r <= fpc_nxt_s;
      case (state_r)
        IDLE: begin
          if (start_i && room_s) begin
            state_r    <= FETCH;
            req_r      <= 1'b1;
            req_addr_r <= fpc_nxt_s;
          end else begin
            state_r <= IDLE;
            req_r   <= 1'b0;
          end
        end
        FETCH: begin
          if (imem_ack_i) begin
            if (start_i && room_s) begin
              state_r    <= FETCH;
              req_r      <= 1'b1;
              req_addr_r <= fpc_nxt_s;
            end else begin
              state_r <= IDLE;
              req_r   <= 1'b0;
            end
          end else if (redirect_i) begin
            // keep the stale request alive; its data is dropped on ack
            state_r <= DROP;
            req_r   <= 1'b1;
          end else begin
            state_r <= FETCH;
            req_r   <= 1'b1;
          end
        end
        DROP: begin
          if (imem_ack_i) begin
            if (start_i && room_s) begin
              state_r    <= FETCH;
              req_r      <= 1'b1;
              req_addr_r <= fpc_nxt_s;
            end else begin
              state_r <= IDLE;
              req_r   <= 1'b0;
            end
          end else begin
            state_r <= DROP;
            req_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  // Instruction FIFO storage, pointers and occupancy; redirect empties it
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      valid_r  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_r[i] <= 32'd0;
        addr_mem_r[i] <= 32'd0;
      end
    end else begin
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != {CW{1'b0}});
      if (redirect_i) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
      end else begin
        if (push_s) begin
          inst_mem_r[wr_ptr_r] <= imem_data_i;
          addr_mem_r[wr_ptr_r] <= fpc_r + 32'd4;
          wr_ptr_r             <= wr_ptr_r + PW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PW'(1);
        end
      end
    end
  end

  assign imem_req_o  = req_r;
  assign imem_addr_o = req_addr_r;
  assign valid_o     = valid_r;
  assign inst_o      = inst_mem_r[rd_ptr_r];
  assign addr_o      = addr_mem_r[rd_ptr_r];
  assign count_o     = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a memory model with programmable ack latency, a
// reference fetch-PC model and a scoreboard queue of expected FIFO entries,
// plus a table of phases with end-of-phase expectations and hand-written
// redirect / reset sequences.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_i;
  logic          start_i;
  logic          stall_i;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic          imem_req_o;
  logic [31:0]   imem_addr_o;
  logic          imem_ack_i;
  logic [31:0]   imem_data_i;
  logic          valid_o;
  logic [31:0]   inst_o;
  logic [31:0]   addr_o;
  logic [CW-1:0] count_o;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .valid_o(valid_o), .inst_o(inst_o), .addr_o(addr_o), .count_o(count_o)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } ent_t;

  typedef struct {
    bit          start;
    bit          stall;
    int          lat;
    int          ncyc;
    bit          req;
    int          cnt;
    bit          val;
    bit          chk_addr;
    logic [31:0] addr;
  } vec_t;

  ent_t        q[$];
  logic [31:0] exp_pc;
  int          lat;
  int          wait_cnt;
  bit          drop;
  bit          prev_pend;
  logic [31:0] prev_addr;
  int          n_vec;
  int          n_miss;
  vec_t        tbl [11];

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'd7) ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_pc    = 32'h0000_0000;
    wait_cnt  = 0;
    drop      = 1'b0;
    prev_pend = 1'b0;
    prev_addr = 32'h0;
  endtask

  // one clock: check outputs, drive memory response, update model, advance
  task automatic cycle();
    logic ack;
    chk("count", 32'(count_o), 32'(q.size()));
    chk("valid", 32'(valid_o), (q.size() != 0) ? 32'd1 : 32'd0);
    if (valid_o && q.size() != 0) begin
      chk("head_inst", inst_o, q[0].inst);
      chk("head_addr", addr_o, q[0].addr);
    end
    if (prev_pend) begin
      chk("req_held", 32'(imem_req_o), 32'd1);
      chk("addr_stable", imem_addr_o, prev_addr);
    end
    ack         = imem_req_o && (wait_cnt >= lat);
    imem_ack_i  = ack;
    imem_data_i = ack ? memfn(imem_addr_o) : 32'h0;
    if (valid_o && !stall_i && !redirect_i && q.size() != 0) void'(q.pop_front());
    if (ack) begin
      if (drop) begin
        drop = 1'b0;
      end else begin
        chk("req_addr", imem_addr_o, exp_pc);
        if (!redirect_i) begin
          q.push_back('{inst: memfn(exp_pc), addr: exp_pc + 32'd4});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    if (redirect_i) begin
      if (imem_req_o && !ack) drop = 1'b1;
      q.delete();
      exp_pc = redirect_pc_i;
    end
    prev_pend = imem_req_o && !ack;
    prev_addr = imem_addr_o;
    wait_cnt  = (imem_req_o && !ack) ? wait_cnt + 1 : 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    imem_ack_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
  endtask

  // watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // main stimulus
  initial begin
    bit seen;
    n_vec = 0; n_miss = 0;
    start_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_ack_i = 1'b0; imem_data_i = 32'h0; lat = 0;
    //            start stall lat n  req cnt val chka addr
    tbl[0]  = '{1'b1, 1'b1, 0, 1, 1'b1, 0, 1'b0, 1'b1, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 0, 4, 1'b0, 4, 1'b1, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 0, 2, 1'b0, 4, 1'b1, 1'b0, 32'h00};
    tbl[3]  = '{1'b1, 1'b0, 0, 1, 1'b1, 3, 1'b1, 1'b1, 32'h10};
    tbl[4]  = '{1'b1, 1'b0, 0, 6, 1'b1, 3, 1'b1, 1'b1, 32'h28};
    tbl[5]  = '{1'b0, 1'b0, 0, 1, 1'b0, 3, 1'b1, 1'b0, 32'h00};
    tbl[6]  = '{1'b0, 1'b0, 0, 3, 1'b0, 0, 1'b0, 1'b0, 32'h00};
    tbl[7]  = '{1'b1, 1'b0, 3, 1, 1'b1, 0, 1'b0, 1'b1, 32'h2C};
    tbl[8]  = '{1'b1, 1'b0, 3, 3, 1'b1, 0, 1'b0, 1'b1, 32'h2C};
    tbl[9]  = '{1'b1, 1'b0, 3, 1, 1'b1, 1, 1'b1, 1'b1, 32'h30};
    tbl[10] = '{1'b1, 1'b0, 3, 4, 1'b1, 1, 1'b1, 1'b1, 32'h34};

    rst_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_imem_addr", imem_addr_o, 32'h0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_count", 32'(count_o), 32'd0);
    rst_i = 1'b1;

    // table of phases: stall-fill, drain, zero-wait streaming, 3-cycle latency
    for (int i = 0; i < 11; i++) begin
      start_i = tbl[i].start;
      stall_i = tbl[i].stall;
      lat     = tbl[i].lat;
      repeat (tbl[i].ncyc) cycle();
      chk($sformatf("v%0d_req", i), 32'(imem_req_o), 32'(tbl[i].req));
      chk($sformatf("v%0d_count", i), 32'(count_o), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_valid", i), 32'(valid_o), 32'(tbl[i].val));
      if (tbl[i].chk_addr) chk($sformatf("v%0d_imem_addr", i), imem_addr_o, tbl[i].addr);
    end

    // redirect with request outstanding and 3 entries queued -> DROP
    do_reset();
    start_i = 1'b1; stall_i = 1'b1; lat = 0;
    repeat (4) cycle();
    chk("pre_redir_count", 32'(count_o), 32'd3);
    chk("pre_redir_addr", imem_addr_o, 32'h0C);
    lat = 5;
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    cycle();
    redirect_i = 1'b0; stall_i = 1'b0;
    chk("drop_count", 32'(count_o), 32'd0);
    chk("drop_valid", 32'(valid_o), 32'd0);
    chk("drop_req", 32'(imem_req_o), 32'd1);
    chk("drop_stale_addr", imem_addr_o, 32'h0C);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle();
      seen = valid_o;
    end
    chk("drop_valid_seen", 32'(seen), 32'd1);
    chk("drop_first_addr", addr_o, 32'h44);
    chk("drop_first_inst", inst_o, memfn(32'h40));

    // redirect coinciding with ack -> straight to target, no DROP
    lat = 0;
    repeat (2) cycle();
    redirect_i = 1'b1; redirect_pc_i = 32'h80;
    cycle();
    redirect_i = 1'b0;
    chk("rda_req", 32'(imem_req_o), 32'd1);
    chk("rda_addr", imem_addr_o, 32'h80);
    chk("rda_count", 32'(count_o), 32'd0);
    cycle();
    chk("rda_valid", 32'(valid_o), 32'd1);
    chk("rda_head_addr", addr_o, 32'h84);

    // asynchronous reset mid-FETCH with 2 entries queued
    stall_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      seen = (count_o == CW'(2));
    end
    chk("mid_count_seen", 32'(seen), 32'd1);
    chk("mid_req", 32'(imem_req_o), 32'd1);
    imem_ack_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req_o), 32'd0);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_count", 32'(count_o), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    stall_i = 1'b0; lat = 0;
    cycle();
    chk("restart_req", 32'(imem_req_o), 32'd1);
    chk("restart_addr", imem_addr_o, 32'h0);
    cycle();
    chk("restart_valid", 32'(valid_o), 32'd1);
    chk("restart_head", addr_o, 32'h4);
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
